// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// States, stream-format constants and the count-byte decode.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int TIMEOUT_DEF    = 1024;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT0_WORDS   = 256;
  localparam int WCNT_W         = 9;

  // A count byte of zero stands for the largest image
  function automatic logic [WCNT_W-1:0] word_count(
    input logic [7:0] c
  );
    return (c == 8'd0) ? WCNT_W'(COUNT0_WORDS)
                       : {1'b0, c};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port out.
// The loader sits on the slave side.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Packs big-endian bytes into 32-bit words.
// stb pulses the cycle after a word's fourth byte.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last,
  output logic        stb
);
  logic [1:0] idx;

  assign last = shift &&
    (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      word <= '0;
      idx  <= '0;
      stb  <= 1'b0;
    end else begin
      stb <= last;
      if (clr) begin
        word <= '0;
        idx  <= '0;
      end else if (shift) begin
        word <= {word[23:0], din};
        idx  <= idx + 2'd1;
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Loads a counted, XOR-checked byte stream into
// instruction memory and holds the CPU in reset until it is good.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 8
) (
  input  logic         clk,
  input  logic         rstd,
  input  logic         load_req,
  prog_loader_if.slave bus,
  output logic         cpu_rstd,
  output logic         done,
  output logic         err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [TW-1:0]     tcnt;
  logic [WCNT_W-1:0] wcnt, nwords;
  logic [7:0]        csum;
  logic [31:0]       word;
  logic active, xfer, start, expired;
  logic shift, last_b, stb, last_w;

  assign active  = state inside
    {S_COUNT, S_DATA, S_CHECK};
  assign xfer    = active && bus.rx_valid;
  assign start   = load_req && (state inside
    {S_IDLE, S_DONE, S_ERR});
  assign expired = active && !bus.rx_valid &&
    (tcnt == TW'(TIMEOUT - 1));
  assign shift   = (state == S_DATA) && xfer;
  assign last_w  = (wcnt + WCNT_W'(1)) == nwords;

  assign bus.rx_ready = active;
  assign bus.im_we    = stb;
  assign bus.im_addr  = ADDR_W'(wcnt);
  assign bus.im_wdata = word;
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign cpu_rstd = (state == S_DONE);

  word_packer u_pack (
    .clk   (clk),
    .rstd  (rstd),
    .clr   (start),
    .shift (shift),
    .din   (bus.rx_data),
    .word  (word),
    .last  (last_b),
    .stb   (stb)
  );

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) state <= S_IDLE;
    else       state <= state_n;
  end

  // Leave DATA on the last byte itself so the checksum byte
  // is never mistaken for data while the final write is pending
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_n = S_COUNT;
      S_COUNT:
        if (xfer)         state_n = S_DATA;
        else if (expired) state_n = S_ERR;
      S_DATA:
        if (last_b && last_w) state_n = S_CHECK;
        else if (expired)     state_n = S_ERR;
      S_CHECK:
        if (xfer)
          state_n = (bus.rx_data == csum) ?
            S_DONE : S_ERR;
        else if (expired) state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  // Address holds at the last word rather than wrapping
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      tcnt   <= '0;
      wcnt   <= '0;
      nwords <= '0;
      csum   <= '0;
    end else if (start) begin
      tcnt <= '0;
      wcnt <= '0;
      csum <= '0;
    end else begin
      if (active)
        tcnt <= xfer ? '0 : tcnt + TW'(1);
      if (state == S_COUNT && xfer)
        nwords <= word_count(bus.rx_data);
      if (shift)
        csum <= csum ^ bus.rx_data;
      if (stb && !last_w)
        wcnt <= wcnt + WCNT_W'(1);
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed checks for the program loader.
// Writes are logged on the falling edge.
module tb_prog_loader;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstd = 1'b0;
  logic load_req = 1'b0;
  logic cpu_rstd, done, err;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  logic [31:0]   wdat [0:511];
  logic [AW-1:0] wadr [0:511];
  logic [7:0]    sb   [0:1023];

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rstd     (rstd),
    .load_req (load_req),
    .bus      (bus),
    .cpu_rstd (cpu_rstd),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1 && wcount < 512) begin
      wdat[wcount] = bus.im_wdata;
      wadr[wcount] = bus.im_addr;
      wcount++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic int bad_words(
    input int base, input int nw
  );
    int n;
    logic [31:0] w;
    n = 0;
    for (int i = 0; i < nw; i++) begin
      w = {sb[4*i], sb[4*i+1], sb[4*i+2], sb[4*i+3]};
      if (wdat[base+i] !== w) n++;
      if (wadr[base+i] !== AW'(i)) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send_byte(
    input logic [7:0] b, input bit rnd
  );
    int w;
    if (rnd) begin
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    w = 0;
    while (bus.rx_ready !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    if (bus.rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte: rx_ready=%b want 1",
        bus.rx_ready);
    end
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic load_prog(
    input int nw, input bit rnd, input bit bad,
    input logic [7:0] bad_ck, output int base
  );
    logic [7:0] x;
    x = 8'h00;
    base = wcount;
    pulse_load();
    send_byte(8'(nw), rnd);
    for (int i = 0; i < 4*nw; i++) begin
      send_byte(sb[i], rnd);
      x ^= sb[i];
    end
    send_byte(bad ? bad_ck : x, rnd);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.rx_ready, bus.im_we, cpu_rstd, done, err}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
        {bus.rx_ready, bus.im_we, cpu_rstd, done, err});
    end
    checks++;
    if (bus.im_addr !== '0 || bus.im_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h want 0",
        bus.im_addr, bus.im_wdata);
    end
    repeat (2) step();
    rstd = 1'b1;
    step();
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0",
        bus.rx_ready);
    end
  endtask

  task automatic test_good();
    logic [31:0] wv [2];
    int base;
    wv[0] = 32'h11223344;
    wv[1] = 32'hAABBCCDD;
    for (int i = 0; i < 8; i++)
      sb[i] = wv[i/4][31-8*(i%4) -: 8];
    base = wcount;
    pulse_load();
    send_byte(8'h02, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        send_byte(sb[4*k+j], 1'b0);
      checks++;
      if (bus.im_we !== 1'b1 ||
          bus.im_addr !== AW'(k) ||
          bus.im_wdata !== wv[k]) begin
        errors++;
        $display("FAIL good_wr%0d: we=%b a=%h d=%h want 1 %0d %h",
          k, bus.im_we, bus.im_addr, bus.im_wdata, k, wv[k]);
      end
    end
    send_byte(8'h44, 1'b0);
    checks++;
    if (wcount - base !== 2) begin
      errors++;
      $display("FAIL good_cnt: got %0d want 2", wcount - base);
    end
    checks++;
    if (bad_words(base, 2) !== 0) begin
      errors++;
      $display("FAIL good_words: %0d bad want 0",
        bad_words(base, 2));
    end
    checks++;
    if ({done, err, cpu_rstd, bus.rx_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL good_state: d/e/c/r=%b want 1010",
        {done, err, cpu_rstd, bus.rx_ready});
    end
    base = wcount;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) step();
    bus.rx_valid = 1'b0;
    step();
    checks++;
    if (wcount - base !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL valid_no_ready: writes=%0d done=%b want 0 1",
        wcount - base, done);
    end
  endtask

  task automatic test_bad();
    logic [7:0] cks [2];
    int base;
    cks[0] = 8'h01;
    cks[1] = 8'h00;
    for (int t = 0; t < 2; t++) begin
      pulse_load();
      checks++;
      if ({done, err, cpu_rstd, bus.rx_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL restart_clr%0d: d/e/c/r=%b want 0001",
          t, {done, err, cpu_rstd, bus.rx_ready});
      end
      load_prog(2, 1'b0, 1'b1, cks[t], base);
      checks++;
      if (wcount - base !== 2 || bad_words(base, 2) !== 0) begin
        errors++;
        $display("FAIL bad_words%0d: n=%0d bad=%0d want 2 0",
          t, wcount - base, bad_words(base, 2));
      end
      checks++;
      if ({done, err, cpu_rstd} !== 3'b010) begin
        errors++;
        $display("FAIL bad_state%0d: d/e/c=%b want 010",
          t, {done, err, cpu_rstd});
      end
    end
  endtask

  task automatic test_full();
    int base;
    for (int i = 0; i < 1024; i++)
      sb[i] = 8'(i * 37 + 5);
    load_prog(256, 1'b0, 1'b0, 8'h00, base);
    checks++;
    if (wcount - base !== 256) begin
      errors++;
      $display("FAIL full_cnt: got %0d want 256", wcount - base);
    end
    checks++;
    if (bad_words(base, 256) !== 0) begin
      errors++;
      $display("FAIL full_words: %0d bad want 0",
        bad_words(base, 256));
    end
    checks++;
    if ({done, err, cpu_rstd} !== 3'b101) begin
      errors++;
      $display("FAIL full_state: d/e/c=%b want 101",
        {done, err, cpu_rstd});
    end
  endtask

  task automatic test_random();
    int b0, b1;
    sb[0] = 8'hDE; sb[1] = 8'hAD;
    sb[2] = 8'hBE; sb[3] = 8'hEF;
    load_prog(1, 1'b0, 1'b0, 8'h00, b0);
    load_prog(1, 1'b1, 1'b0, 8'h00, b1);
    checks++;
    if (wcount - b1 !== 1 || wdat[b1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rnd_word: n=%0d d=%h want 1 deadbeef",
        wcount - b1, wdat[b1]);
    end
    checks++;
    if (wdat[b0] !== 32'hDEADBEEF || done !== 1'b1) begin
      errors++;
      $display("FAIL rnd_done: b2b=%h done=%b want deadbeef 1",
        wdat[b0], done);
    end
  endtask

  task automatic test_timeout();
    int base;
    base = wcount;
    pulse_load();
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 3; i++)
      send_byte(8'(8'h70 + i), 1'b0);
    repeat (TO - 1) step();
    checks++;
    if (err !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_early: err=%b rdy=%b want 0 1",
        err, bus.rx_ready);
    end
    step();
    checks++;
    if ({done, err, cpu_rstd, bus.rx_ready} !== 4'b0100) begin
      errors++;
      $display("FAIL to_err: d/e/c/r=%b want 0100",
        {done, err, cpu_rstd, bus.rx_ready});
    end
    checks++;
    if (wcount - base !== 0) begin
      errors++;
      $display("FAIL to_nowr: got %0d want 0", wcount - base);
    end
  endtask

  task automatic test_reset_mid();
    int base, b2;
    for (int i = 0; i < 8; i++)
      sb[i] = 8'(i + 1);
    base = wcount;
    pulse_load();
    send_byte(8'h02, 1'b0);
    send_byte(sb[0], 1'b0);
    send_byte(sb[1], 1'b0);
    pulse_load();
    for (int i = 2; i < 5; i++)
      send_byte(sb[i], 1'b0);
    checks++;
    if (bus.im_addr !== AW'(1) ||
        bus.im_wdata !== 32'h02030405) begin
      errors++;
      $display("FAIL mid_pre: a=%h d=%h want 01 02030405",
        bus.im_addr, bus.im_wdata);
    end
    rstd = 1'b0;
    #1;
    checks++;
    if ({bus.rx_ready, bus.im_we, cpu_rstd, done, err}
        !== 5'b0 || bus.im_addr !== '0 ||
        bus.im_wdata !== '0) begin
      errors++;
      $display("FAIL mid_rst: ctl=%b a=%h d=%h want 0",
        {bus.rx_ready, bus.im_we, cpu_rstd, done, err},
        bus.im_addr, bus.im_wdata);
    end
    repeat (3) step();
    rstd = 1'b1;
    repeat (3) step();
    checks++;
    if (wcount - base !== 1 || wdat[base] !== 32'h01020304) begin
      errors++;
      $display("FAIL mid_partial: n=%0d d=%h want 1 01020304",
        wcount - base, wdat[base]);
    end
    load_prog(1, 1'b0, 1'b0, 8'h00, b2);
    checks++;
    if (wcount - b2 !== 1 || wdat[b2] !== 32'h01020304 ||
        done !== 1'b1 || cpu_rstd !== 1'b1) begin
      errors++;
      $display("FAIL mid_reload: n=%0d d=%h done=%b c=%b",
        wcount - b2, wdat[b2], done, cpu_rstd);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_good();
    test_bad();
    test_full();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end
endmodule
